// File: rtl/lbp_pkg.sv
// Shared types and helpers for the LBP stream engine: FSM states, code bit
// positions of each neighbour and the edge-clamp used for replicate padding.
package lbp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } lbp_state_t;

    // Bit position of each neighbour in the code, named by compass direction
    localparam int BIT_NW = 0;
    localparam int BIT_N  = 1;
    localparam int BIT_NE = 2;
    localparam int BIT_W  = 3;
    localparam int BIT_E  = 4;
    localparam int BIT_SW = 5;
    localparam int BIT_S  = 6;
    localparam int BIT_SE = 7;

    function automatic int clamp(input int v, input int hi);
        if (v < 0) begin
            return 0;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/lbp_window.sv
// 3x3 pixel window with left-shift and indexed load, plus the eight
// neighbour-versus-centre comparators that form the LBP code.
module lbp_window
    import lbp_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int CMP_GT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             shift_en,
    input  logic [1:0]       wr_row,
    input  logic [1:0]       wr_col,
    input  logic [PIX_W-1:0] din,
    output logic [7:0]       code
);

    logic [PIX_W-1:0] win [3][3];

    // A shift and the write of the new right column share one edge
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            if (shift_en) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
            end
            if (wr_en) begin
                win[wr_row][wr_col] <= din;
            end
        end
    end

    function automatic logic sets(input logic [PIX_W-1:0] n, input logic [PIX_W-1:0] c);
        return (CMP_GT != 0) ? (n > c) : (n >= c);
    endfunction

    always_comb begin
        code         = '0;
        code[BIT_NW] = sets(win[0][0], win[1][1]);
        code[BIT_N]  = sets(win[0][1], win[1][1]);
        code[BIT_NE] = sets(win[0][2], win[1][1]);
        code[BIT_W]  = sets(win[1][0], win[1][1]);
        code[BIT_E]  = sets(win[1][2], win[1][1]);
        code[BIT_SW] = sets(win[2][0], win[1][1]);
        code[BIT_S]  = sets(win[2][1], win[1][1]);
        code[BIT_SE] = sets(win[2][2], win[1][1]);
    end

endmodule

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine: reads a grey image, writes one code per centre pixel.
// Define LBP_BORDER_EN to also emit border pixels using replicate padding.
module lbp_stream_engine
    import lbp_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int CMP_GT = 0,
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [PIX_W-1:0]  gray_data,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              finish
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
`ifdef LBP_BORDER_EN
    localparam int XMIN = 0;
    localparam int XMAX = IMG_W - 1;
    localparam int YMIN = 0;
    localparam int YMAX = IMG_H - 1;
`else
    localparam int XMIN = 1;
    localparam int XMAX = IMG_W - 2;
    localparam int YMIN = 1;
    localparam int YMAX = IMG_H - 2;
`endif
    localparam logic [CW-1:0] X_FIRST = CW'(XMIN);
    localparam logic [CW-1:0] X_LAST  = CW'(XMAX);
    localparam logic [RW-1:0] Y_FIRST = RW'(YMIN);
    localparam logic [RW-1:0] Y_LAST  = RW'(YMAX);

    lbp_state_t        state, state_nxt;
    logic [CW-1:0]     cx;
    logic [RW-1:0]     cy;
    logic [3:0]        idx;
    logic [1:0]        rd_col, rd_row;
    logic              last_read, shift_en, pend;
    logic [ADDR_W-1:0] emit_addr;
    logic [7:0]        code;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The last read of a window decides whether to slide, start the next row or stop
    always_comb begin
        state_nxt = state;
        gray_req  = 1'b0;
        last_read = 1'b0;
        case (state)
            IDLE: begin
                if (gray_ready) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                gray_req  = gray_ready;
                last_read = gray_ready && (idx == 4'd8);
            end
            SHIFT: begin
                gray_req  = gray_ready;
                last_read = gray_ready && (idx == 4'd2);
            end
            default: begin
            end
        endcase
        if (last_read) begin
            if (cx != X_LAST) begin
                state_nxt = SHIFT;
            end else if (cy != Y_LAST) begin
                state_nxt = LOAD;
            end else begin
                state_nxt = DONE;
            end
        end
    end

    // cx/cy are the centre of the window being assembled; SHIFT only fetches column +1
    always_comb begin
        int rx, ry;
        rd_col = (state == SHIFT) ? 2'd2 : 2'(int'(idx) / 3);
        rd_row = (state == SHIFT) ? idx[1:0] : 2'(int'(idx) % 3);
        rx     = int'(cx) + int'(rd_col) - 1;
        ry     = int'(cy) + int'(rd_row) - 1;
`ifdef LBP_BORDER_EN
        rx     = clamp(rx, IMG_W - 1);
        ry     = clamp(ry, IMG_H - 1);
`endif
        gray_addr = ADDR_W'(ry * IMG_W + rx);
    end

    assign shift_en = gray_req && (state == SHIFT) && (idx == 4'd0);

    lbp_window #(
        .PIX_W  (PIX_W),
        .CMP_GT (CMP_GT)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (gray_req),
        .shift_en (shift_en),
        .wr_row   (rd_row),
        .wr_col   (rd_col),
        .din      (gray_data),
        .code     (code)
    );

    // A completed window is emitted one cycle later, overlapping the next column's reads
    always_ff @(posedge clk) begin
        if (reset) begin
            cx        <= X_FIRST;
            cy        <= Y_FIRST;
            idx       <= '0;
            pend      <= 1'b0;
            emit_addr <= '0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
            finish    <= 1'b0;
        end else begin
            pend      <= last_read;
            lbp_valid <= pend;
            finish    <= (state == DONE) && !pend;
            if (pend) begin
                lbp_addr <= emit_addr;
                lbp_data <= code;
            end
            if (last_read) begin
                emit_addr <= ADDR_W'(int'(cy) * IMG_W + int'(cx));
                idx       <= '0;
                if (cx != X_LAST) begin
                    cx <= cx + 1'b1;
                end else begin
                    cx <= X_FIRST;
                    if (cy != Y_LAST) begin
                        cy <= cy + 1'b1;
                    end
                end
            end else if (gray_req) begin
                idx <= idx + 4'd1;
            end
        end
    end

endmodule
